// File: rtl/counter_seq.sv
// One-shot timeout counter: a start strobe arms it, it counts 0..max, then pulses strb for one cycle and goes idle.
// Latency: with enable high, strb is asserted in the cycle after edge max+1 counted from the start edge; each enable-low cycle adds one.
// Backpressure: none; enable low freezes the count, and start_strb always restarts the count, even while running.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset (priority over everything)
//   enable     - count-advance qualifier; low holds cntr while running
//   start_strb - start/restart request; discards any count in progress
//   cntr       - registered current count, 0 when idle, never exceeds max
//   strb       - registered terminal-count strobe, one cycle wide
module counter_seq #(
  parameter int unsigned     dw  = 8,
  parameter logic [dw-1:0]   max = 8'd255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start_strb,
  output logic [dw-1:0] cntr,
  output logic          strb
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [dw-1:0] cntr_q,  cntr_d;
  logic          strb_q,  strb_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cntr_d  = '0;
    strb_d  = 1'b0;

    if (start_strb) begin
      // A restart wins even on the terminal-count cycle, so the old count
      // never produces a strobe.
      state_d = COUNT;
      cntr_d  = '0;
    end else if (state_q == COUNT) begin
      if (enable) begin
        if (cntr_q == max) begin
          // Terminal count: pulse once and fall back to idle with cntr=0.
          strb_d  = 1'b1;
          state_d = IDLE;
          cntr_d  = '0;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end else begin
        cntr_d = cntr_q;
      end
    end else begin
      state_d = IDLE;
      cntr_d  = '0;
    end
  end

  assign cntr = cntr_q;
  assign strb = strb_q;

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq: four instances with different widths/terminal values share stimulus.
// Expected cntr/strb per cycle are queued alongside each stimulus cycle and compared after the edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_counter_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       start_strb = 1'b0;

  logic [1:0] cntr_a;  logic strb_a;   // dw=2, max=2
  logic [2:0] cntr_b;  logic strb_b;   // dw=3, max=5
  logic [1:0] cntr_c;  logic strb_c;   // dw=2, max=0
  logic [3:0] cntr_d;  logic strb_d;   // dw=4, max=15

  int checks = 0;
  int errors = 0;

  typedef struct { logic s; logic e; logic r; } stim_t;
  typedef struct { int unsigned c; logic st; } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int          sel;
  logic [31:0] act_c;
  logic        act_s;

  always #5 clk = ~clk;

  counter_seq #(.dw(2), .max(2'd2)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_a), .strb(strb_a));
  counter_seq #(.dw(3), .max(3'd5)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_b), .strb(strb_b));
  counter_seq #(.dw(2), .max(2'd0)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_c), .strb(strb_c));
  counter_seq #(.dw(4), .max(4'd15)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .start_strb(start_strb),
    .cntr(cntr_d), .strb(strb_d));

  // Queue one stimulus cycle together with the outputs expected after its edge.
  task automatic push(input logic s, input logic e, input logic r,
                      input int unsigned c, input logic st);
    stim_t si;
    exp_t  ex;
    si.s = s; si.e = e; si.r = r;
    ex.c = c; ex.st = st;
    stim_q.push_back(si);
    exp_q.push_back(ex);
  endtask

  // Apply one stimulus cycle and capture the selected instance's outputs.
  task automatic drive(input stim_t si);
    @(negedge clk);
    start_strb = si.s;
    enable     = si.e;
    reset      = si.r;
    @(posedge clk);
    #1;
    case (sel)
      0:       begin act_c = {30'b0, cntr_a}; act_s = strb_a; end
      1:       begin act_c = {29'b0, cntr_b}; act_s = strb_b; end
      2:       begin act_c = {30'b0, cntr_c}; act_s = strb_c; end
      default: begin act_c = {28'b0, cntr_d}; act_s = strb_d; end
    endcase
  endtask

  // Expected sequence for an uninterrupted timeout: start, 0..max, strobe, idle.
  task automatic push_timeout(input int unsigned maxv);
    push(1, 1, 0, 0, 0);
    for (int i = 1; i <= int'(maxv); i++) push(0, 1, 0, i, 0);
    push(0, 1, 0, 0, 1);
    push(0, 1, 0, 0, 0);
    push(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = 0;
    push(0, 0, 1, 0, 0);
    push(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) push(0, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL reset cyc%0d cntr got %0d expected %0d", cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL reset cyc%0d strb got %b expected %b", cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  task automatic test_timeout(input string name, input int s, input int unsigned maxv);
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = s;
    push_timeout(maxv);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL %s cyc%0d cntr got %0d expected %0d", name, cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL %s cyc%0d strb got %b expected %b", name, cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  task automatic test_stall();
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = 0;
    push(1, 1, 0, 0, 0);
    push(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 1, 0);
    push(0, 1, 0, 2, 0);
    push(0, 1, 0, 0, 1);
    push(0, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL stall cyc%0d cntr got %0d expected %0d", cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL stall cyc%0d strb got %b expected %b", cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  task automatic test_retrigger();
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = 1;
    push(1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) push(0, 1, 0, i, 0);
    push(1, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) push(0, 1, 0, i, 0);
    push(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) push(0, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL retrigger cyc%0d cntr got %0d expected %0d", cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL retrigger cyc%0d strb got %b expected %b", cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = 1;
    push(1, 1, 0, 0, 0);
    push(0, 1, 0, 1, 0);
    push(0, 1, 0, 2, 0);
    push(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) push(0, 1, 0, 0, 0);
    push_timeout(5);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL reset_mid cyc%0d cntr got %0d expected %0d", cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL reset_mid cyc%0d strb got %b expected %b", cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  // Held start keeps restarting; a start on the terminal-count cycle
  // suppresses that strobe; start is accepted with enable low.
  task automatic test_back_to_back();
    stim_t si;
    exp_t  ex;
    int    cyc = 0;
    sel = 0;
    for (int i = 0; i < 3; i++) push(1, 1, 0, 0, 0);
    push(0, 1, 0, 1, 0);
    push(0, 1, 0, 2, 0);
    push(1, 1, 0, 0, 0);
    push(0, 1, 0, 1, 0);
    push(0, 1, 0, 2, 0);
    push(0, 1, 0, 0, 1);
    push(1, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    push(0, 1, 0, 1, 0);
    push(0, 1, 0, 2, 0);
    push(0, 1, 0, 0, 1);
    push(0, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      si = stim_q.pop_front();
      drive(si);
      ex = exp_q.pop_front();
      checks++;
      if (act_c !== ex.c) begin
        errors++;
        $display("FAIL back_to_back cyc%0d cntr got %0d expected %0d", cyc, act_c, ex.c);
      end
      checks++;
      if (act_s !== ex.st) begin
        errors++;
        $display("FAIL back_to_back cyc%0d strb got %b expected %b", cyc, act_s, ex.st);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_timeout("basic", 0, 2);
    test_stall();
    test_retrigger();
    test_reset_mid();
    test_timeout("max0", 2, 0);
    test_timeout("max15", 3, 15);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
